// File: rtl/handshake_constant_rep.sv
// handshake_constant_rep: constant token source for dataflow circuits.
// Every token accepted on the ctrl channel produces REPEAT output tokens that
// carry CONST_VALUE. outs_valid comes straight from the state register, so
// there is no combinational path from ctrl_valid to outs_valid.
// Optional build macro: HANDSHAKE_CONSTANT_IDX_EN adds the outs_idx port,
// which reports the repetition index of the token currently on outs.
module handshake_constant_rep #(
    parameter int unsigned              DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]    CONST_VALUE = '1,
    parameter int unsigned              REPEAT      = 1,
    localparam int unsigned             CW          = (REPEAT > 1) ? $clog2(REPEAT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_IDX_EN
    ,
    output logic [CW-1:0]         outs_idx
`endif
);

    // A zero repeat count (or one the counter cannot represent) is refused at elaboration.
    if (REPEAT < 1 || REPEAT > 65535) begin : g_bad_repeat
        $error("handshake_constant_rep: REPEAT must be in 1..65535");
    end

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(REPEAT - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            out_fire;
    logic            ctrl_fire;

    assign outs       = CONST_VALUE;
    assign outs_valid = (state == EMIT);
    assign last       = (cnt == LAST_CNT);
    assign out_fire   = outs_valid & outs_ready;
    assign ctrl_fire  = ctrl_valid & ctrl_ready;

    // Accept a new ctrl token when idle, or on the final repetition's fire so chained tokens leave no bubble.
    always_comb begin
        ctrl_ready = !rst & ((state == IDLE) | ((state == EMIT) & out_fire & last));
    end

    // Repetition FSM: count fires up to REPEAT-1, then either chain into the next token or go idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_fire) begin
                        state <= EMIT;
                        cnt   <= '0;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (!last) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            cnt <= '0;
                            if (!ctrl_fire) begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HANDSHAKE_CONSTANT_IDX_EN
    // The counter only moves on an output fire, so the index is stable under backpressure.
    always_comb begin
        outs_idx = cnt;
    end
`endif

endmodule
